hps_cmd_bridge: RTL and testbench



---
 rtl/hps_bridge_pkg.sv | 22 ++
 rtl/hps_cmd_fifo.sv | 57 +++++
 rtl/hps_cmd_bridge.sv | 109 ++++++++++
 tb/tb_hps_cmd_bridge.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hps_bridge_pkg.sv
// Shared constants, response FSM state type and a clog2 helper for the HPS command bridge.
package hps_bridge_pkg;

    // Toggle bit positions inside the PIO word, counted down from DATA_W
    localparam int CMD_REQ_OFS = 1;
    localparam int RSP_ACK_OFS = 2;

    typedef enum logic [0:0] {
        RSP_EMPTY = 1'b0,
        RSP_HELD  = 1'b1
    } rsp_state_t;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/hps_cmd_fifo.sv
// First-word fall-through command FIFO with registered valid/full/count flags.
module hps_cmd_fifo
    import hps_bridge_pkg::*;
#(
    parameter int CMD_W = 30,
    parameter int DEPTH = 8,
    localparam int AW   = clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [CMD_W-1:0] wr_data,
    input  logic             pop,
    output logic [CMD_W-1:0] rd_data,
    output logic             rd_valid,
    output logic             full,
    output logic [AW:0]      count
);

    logic [CMD_W-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [AW:0]      count_nxt;

    always_comb begin
        count_nxt = count;
        case ({push, pop})
            2'b10:   count_nxt = count + 1'b1;
            2'b01:   count_nxt = count - 1'b1;
            default: count_nxt = count;
        endcase
    end

    // Storage is cleared on reset so the head output reads zero while empty after reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            rd_valid <= 1'b0;
            full     <= 1'b0;
        end else begin
            if (push) begin
                mem[wr_ptr[AW-1:0]] <= wr_data;
                wr_ptr              <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count    <= count_nxt;
            rd_valid <= (count_nxt != '0);
            full     <= (count_nxt == (AW+1)'(DEPTH));
        end
    end

    assign rd_data = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/hps_cmd_bridge.sv
// HPS PIO to accelerator command/response bridge using toggle handshakes.
// Optional saturating push counter on port cmd_count when HPS_BRIDGE_CMD_CNT_EN is defined.
module hps_cmd_bridge
    import hps_bridge_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 8,
    localparam int CMD_W = DATA_W - 2,
    localparam int RSP_W = DATA_W - 3
) (
    input  logic              clk_clk,
    input  logic              reset_reset_n,
    input  logic [DATA_W-1:0] pio_out,
    output logic [DATA_W-1:0] pio_in,
    output logic              pio_status,
    output logic              cmd_valid,
    input  logic              cmd_ready,
    output logic [CMD_W-1:0]  cmd_data,
    input  logic              rsp_valid,
    output logic              rsp_ready,
`ifdef HPS_BRIDGE_CMD_CNT_EN
    input  logic [RSP_W-1:0]  rsp_data,
    output logic [15:0]       cmd_count
`else
    input  logic [RSP_W-1:0]  rsp_data
`endif
);

    localparam int AW          = clog2(DEPTH);
    localparam int CMD_REQ_BIT = DATA_W - CMD_REQ_OFS;
    localparam int RSP_ACK_BIT = DATA_W - RSP_ACK_OFS;

    logic             cmd_ack_tgl;
    logic             rsp_ack_q;
    rsp_state_t       rsp_state;
    logic [RSP_W-1:0] rsp_buf;
    logic             cmd_full;
    logic [AW:0]      fifo_count;
    logic             cmd_pending;
    logic             push;
    logic             pop;

    assign cmd_pending = pio_out[CMD_REQ_BIT] != cmd_ack_tgl;
    assign pop         = cmd_valid && cmd_ready;
    // A full FIFO still accepts a push when the head leaves in the same cycle
    assign push        = cmd_pending && ((fifo_count < (AW+1)'(DEPTH)) || pop);

    hps_cmd_fifo #(
        .CMD_W (CMD_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk_clk),
        .rst_n    (reset_reset_n),
        .push     (push),
        .wr_data  (pio_out[CMD_W-1:0]),
        .pop      (pop),
        .rd_data  (cmd_data),
        .rd_valid (cmd_valid),
        .full     (cmd_full),
        .count    (fifo_count)
    );

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            cmd_ack_tgl <= 1'b0;
        end else if (push) begin
            cmd_ack_tgl <= ~cmd_ack_tgl;
        end
    end

    // Response holding register: released only by an HPS ack toggle
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            rsp_state <= RSP_EMPTY;
            rsp_ack_q <= 1'b0;
            rsp_buf   <= '0;
        end else begin
            case (rsp_state)
                RSP_EMPTY: begin
                    if (rsp_valid) begin
                        rsp_buf   <= rsp_data;
                        rsp_state <= RSP_HELD;
                    end
                end
                default: begin
                    if (pio_out[RSP_ACK_BIT] != rsp_ack_q) begin
                        rsp_ack_q <= ~rsp_ack_q;
                        rsp_state <= RSP_EMPTY;
                    end
                end
            endcase
        end
    end

    assign rsp_ready  = (rsp_state == RSP_EMPTY);
    assign pio_status = cmd_full;
    assign pio_in     = {cmd_ack_tgl, (rsp_state == RSP_HELD), cmd_full, rsp_buf};

`ifdef HPS_BRIDGE_CMD_CNT_EN
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            cmd_count <= '0;
        end else if (push && (cmd_count != 16'hFFFF)) begin
            cmd_count <= cmd_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_hps_cmd_bridge.sv
// Scoreboard bench for hps_cmd_bridge (DATA_W=32, DEPTH=8, default build).
module tb_hps_cmd_bridge;

    localparam int DATA_W = 32;
    localparam int DEPTH  = 8;
    localparam int CMD_W  = DATA_W - 2;
    localparam int RSP_W  = DATA_W - 3;

    logic              clk_clk;
    logic              reset_reset_n;
    logic [DATA_W-1:0] pio_out;
    logic [DATA_W-1:0] pio_in;
    logic              pio_status;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [CMD_W-1:0]  cmd_data;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [RSP_W-1:0]  rsp_data;

    int n_checks;
    int n_fail;

    logic req_t;
    logic rack_t;
    logic [CMD_W-1:0] cmd_sb [$];
    logic [RSP_W-1:0] rsp_sb [$];

    hps_cmd_bridge #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) dut (
        .clk_clk       (clk_clk),
        .reset_reset_n (reset_reset_n),
        .pio_out       (pio_out),
        .pio_in        (pio_in),
        .pio_status    (pio_status),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_data      (cmd_data),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_data      (rsp_data)
    );

    initial clk_clk = 1'b0;
    always #5 clk_clk = ~clk_clk;

    task automatic step();
        @(posedge clk_clk);
        #1;
    endtask

    task automatic send_cmd(input logic [CMD_W-1:0] c);
        req_t   = ~req_t;
        pio_out = {req_t, rack_t, c};
        cmd_sb.push_back(c);
    endtask

    task automatic test_reset();
        reset_reset_n = 1'b0;
        step();
        step();
        n_checks++;
        if (pio_in !== '0) begin
            n_fail++; $display("FAIL reset_pio_in: got %h expected %h", pio_in, 32'h0);
        end
        reset_reset_n = 1'b1;
        step();
        step();
        n_checks++;
        if (pio_in !== '0 || pio_status !== 1'b0 || cmd_valid !== 1'b0 || rsp_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_hold: got pio_in=%h status=%b cmd_valid=%b rsp_ready=%b expected 0/0/0/1",
                     pio_in, pio_status, cmd_valid, rsp_ready);
        end
        n_checks++;
        if (cmd_data !== '0) begin
            n_fail++; $display("FAIL reset_cmd_data: got %h expected 0", cmd_data);
        end
    endtask

    task automatic test_single_cmd();
        logic [CMD_W-1:0] exp;
        send_cmd(30'h123);
        n_checks++;
        if (pio_out !== 32'h8000_0123) begin
            n_fail++; $display("FAIL single_stim: got %h expected %h", pio_out, 32'h8000_0123);
        end
        step();
        n_checks++;
        if (pio_in !== 32'h8000_0000) begin
            n_fail++; $display("FAIL single_ack: got pio_in=%h expected %h", pio_in, 32'h8000_0000);
        end
        n_checks++;
        exp = cmd_sb.pop_front();
        if (cmd_valid !== 1'b1 || cmd_data !== exp) begin
            n_fail++; $display("FAIL single_head: got valid=%b data=%h expected 1/%h", cmd_valid, cmd_data, exp);
        end
        cmd_ready = 1'b1;
        step();
        cmd_ready = 1'b0;
        n_checks++;
        if (cmd_valid !== 1'b0) begin
            n_fail++; $display("FAIL single_pop: got cmd_valid=%b expected 0", cmd_valid);
        end
    endtask

    task automatic test_overflow();
        logic [CMD_W-1:0] exp;
        cmd_ready = 1'b0;
        for (int i = 1; i <= 9; i++) begin
            send_cmd(CMD_W'(i));
            step();
            if (i <= 8) begin
                n_checks++;
                if (pio_in[31] !== req_t) begin
                    n_fail++; $display("FAIL ovf_ack_%0d: got %b expected %b", i, pio_in[31], req_t);
                end
            end
            if (i == 8) begin
                n_checks++;
                if (pio_status !== 1'b1 || pio_in[29] !== 1'b1) begin
                    n_fail++; $display("FAIL ovf_full: got status=%b cmd_full=%b expected 1/1", pio_status, pio_in[29]);
                end
            end
        end
        step();
        n_checks++;
        if (pio_in[31] !== ~req_t) begin
            n_fail++; $display("FAIL ovf_withheld: got ack=%b expected %b", pio_in[31], ~req_t);
        end
        n_checks++;
        exp = cmd_sb.pop_front();
        if (cmd_data !== exp) begin
            n_fail++; $display("FAIL ovf_head: got %h expected %h", cmd_data, exp);
        end
        cmd_ready = 1'b1;
        step();
        cmd_ready = 1'b0;
        n_checks++;
        if (pio_in[31] !== req_t || pio_status !== 1'b1) begin
            n_fail++; $display("FAIL ovf_late_ack: got ack=%b status=%b expected %b/1", pio_in[31], pio_status, req_t);
        end
    endtask

    task automatic test_full_push_pop();
        logic [CMD_W-1:0] exp;
        int guard;
        send_cmd(30'hA);
        cmd_ready = 1'b1;
        n_checks++;
        exp = cmd_sb.pop_front();
        if (cmd_data !== exp) begin
            n_fail++; $display("FAIL fpp_head: got %h expected %h", cmd_data, exp);
        end
        step();
        cmd_ready = 1'b0;
        n_checks++;
        if (pio_in[31] !== req_t || pio_status !== 1'b1 || cmd_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL fpp_both: got ack=%b status=%b valid=%b expected %b/1/1", pio_in[31], pio_status, cmd_valid, req_t);
        end
        guard = 0;
        while (cmd_sb.size() != 0 && guard < 40) begin
            guard++;
            if (cmd_valid) begin
                n_checks++;
                exp = cmd_sb.pop_front();
                if (cmd_data !== exp) begin
                    n_fail++; $display("FAIL drain_order: got %h expected %h", cmd_data, exp);
                end
                cmd_ready = 1'b1;
            end else begin
                cmd_ready = 1'b0;
            end
            step();
        end
        cmd_ready = 1'b0;
        n_checks++;
        if (cmd_sb.size() != 0) begin
            n_fail++; $display("FAIL drain_timeout: got %0d left expected 0", cmd_sb.size());
        end
        n_checks++;
        if (cmd_valid !== 1'b0 || pio_status !== 1'b0) begin
            n_fail++; $display("FAIL drain_empty: got valid=%b status=%b expected 0/0", cmd_valid, pio_status);
        end
    endtask

    task automatic test_response();
        logic [RSP_W-1:0] exp;
        rsp_valid = 1'b1;
        rsp_data  = 29'h0ABC_DEF;
        if (rsp_ready) rsp_sb.push_back(rsp_data);
        step();
        rsp_data = 29'h123_4567;
        n_checks++;
        exp = rsp_sb.pop_front();
        if (pio_in[30] !== 1'b1 || pio_in[28:0] !== exp || rsp_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL rsp_capture: got full=%b buf=%h ready=%b expected 1/%h/0", pio_in[30], pio_in[28:0], rsp_ready, exp);
        end
        step();
        step();
        n_checks++;
        if (pio_in[28:0] !== exp || rsp_ready !== 1'b0) begin
            n_fail++; $display("FAIL rsp_holdoff: got buf=%h ready=%b expected %h/0", pio_in[28:0], rsp_ready, exp);
        end
        rack_t  = ~rack_t;
        pio_out = {req_t, rack_t, pio_out[CMD_W-1:0]};
        step();
        n_checks++;
        if (rsp_ready !== 1'b1 || pio_in[30] !== 1'b0 || pio_in[28:0] !== exp) begin
            n_fail++;
            $display("FAIL rsp_release: got ready=%b full=%b buf=%h expected 1/0/%h", rsp_ready, pio_in[30], pio_in[28:0], exp);
        end
        rsp_sb.push_back(rsp_data);
        step();
        rsp_valid = 1'b0;
        n_checks++;
        exp = rsp_sb.pop_front();
        if (pio_in[30] !== 1'b1 || pio_in[28:0] !== exp || rsp_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL rsp_second: got full=%b buf=%h ready=%b expected 1/%h/0", pio_in[30], pio_in[28:0], rsp_ready, exp);
        end
    endtask

    task automatic test_async_reset();
        cmd_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            send_cmd(CMD_W'(30'h100 + i));
            step();
        end
        n_checks++;
        if (cmd_valid !== 1'b1 || pio_in[30] !== 1'b1) begin
            n_fail++; $display("FAIL areset_setup: got valid=%b rsp_full=%b expected 1/1", cmd_valid, pio_in[30]);
        end
        #2;
        reset_reset_n = 1'b0;
        #1;
        n_checks++;
        if (pio_in !== '0 || pio_status !== 1'b0 || cmd_valid !== 1'b0 || rsp_ready !== 1'b1 || cmd_data !== '0) begin
            n_fail++;
            $display("FAIL areset_now: got pio_in=%h status=%b valid=%b ready=%b data=%h expected 0/0/0/1/0",
                     pio_in, pio_status, cmd_valid, rsp_ready, cmd_data);
        end
        req_t   = 1'b0;
        rack_t  = 1'b0;
        pio_out = '0;
        cmd_sb.delete();
        step();
        reset_reset_n = 1'b1;
        step();
        step();
        step();
        n_checks++;
        if (cmd_valid !== 1'b0 || pio_in !== '0 || pio_status !== 1'b0) begin
            n_fail++;
            $display("FAIL areset_no_push: got valid=%b pio_in=%h status=%b expected 0/0/0", cmd_valid, pio_in, pio_status);
        end
    endtask

    initial begin
        n_checks      = 0;
        n_fail        = 0;
        req_t         = 1'b0;
        rack_t        = 1'b0;
        reset_reset_n = 1'b0;
        pio_out       = '0;
        cmd_ready     = 1'b0;
        rsp_valid     = 1'b0;
        rsp_data      = '0;
        test_reset();
        test_single_cmd();
        test_overflow();
        test_full_push_pop();
        test_response();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
